// File: rtl/shazam_frame_sequencer.sv
// shazam_frame_sequencer: ping-pong ADC capture and in-order FFT/peak/SPI dispatch
module shazam_frame_sequencer #(
  parameter int FFT_LENGTH = 1024,
  parameter int ADDR_W = 10,
  parameter int NUM_FRAMES = 3
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              start,
  input  logic [11:0]       adc_data,
  input  logic              adc_data_valid,
  output logic              buf_wr_en,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [11:0]       buf_wr_data,
  output logic              fft_start,
  output logic              fft_bank,
  input  logic              fft_done,
  output logic              peak_start,
  input  logic              peak_done,
  output logic              spi_start,
  input  logic              spi_busy,
  output logic [3:0]        frame_count,
  output logic              overrun,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, FFT_RUN, PEAK_RUN, SPI_WAIT} state_t;
  state_t r_state, w_next;
  logic r_wr_bank, r_proc_bank, r_start_d;
  logic [ADDR_W-1:0] r_wr_idx;
  logic [1:0] r_bank_full, w_set, w_clr;
  logic [7:0] r_frames;
  logic w_rise, w_cap_done, w_cap, w_wr, w_last, w_fft_go, w_peak_go, w_spi_go;
  assign w_rise = start && !r_start_d;
  assign w_cap_done = NUM_FRAMES != 0 && r_frames == 8'(NUM_FRAMES) && !w_rise;
  assign w_cap = adc_data_valid && start && !w_cap_done;
  assign w_wr = w_cap && !r_bank_full[r_wr_bank];
  assign w_last = r_wr_idx == ADDR_W'(FFT_LENGTH - 1);
  assign w_set = (w_wr && w_last) ? 2'b01 << r_wr_bank : 2'b00;
  assign w_clr = w_peak_go ? 2'b01 << r_proc_bank : 2'b00;
  assign fft_bank = r_proc_bank;
  assign busy = r_state != IDLE || |r_bank_full;
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset) begin
      r_start_d   <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_frames    <= '0;
      r_bank_full <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      overrun     <= 1'b0;
    end else begin
      r_start_d   <= start;
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
      buf_wr_en   <= w_wr;
      overrun     <= overrun || (w_cap && r_bank_full[r_wr_bank]);
      r_frames    <= (w_rise ? 8'd0 : r_frames) + 8'(w_wr && w_last);
      if (w_wr) begin
        buf_wr_addr <= {r_wr_bank, r_wr_idx};
        buf_wr_data <= adc_data;
        r_wr_idx    <= w_last ? '0 : r_wr_idx + ADDR_W'(1);
        r_wr_bank   <= r_wr_bank ^ w_last;
      end
    end
  end
  // launching only while spi_start is low guarantees an idle cycle after each dispatch
  always_comb begin
    w_fft_go  = r_state == IDLE && r_bank_full[r_proc_bank] && !spi_start;
    w_peak_go = r_state == FFT_RUN && fft_done;
    w_spi_go  = r_state == SPI_WAIT && !spi_busy;
    w_next    = w_fft_go ? FFT_RUN :
                w_peak_go ? PEAK_RUN :
                (r_state == PEAK_RUN && peak_done) ? SPI_WAIT :
                w_spi_go ? IDLE : r_state;
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_proc_bank <= 1'b0;
      fft_start   <= 1'b0;
      peak_start  <= 1'b0;
      spi_start   <= 1'b0;
      frame_count <= '0;
    end else begin
      r_state     <= w_next;
      r_proc_bank <= r_proc_bank ^ w_spi_go;
      fft_start   <= w_fft_go;
      peak_start  <= w_peak_go;
      spi_start   <= w_spi_go;
      frame_count <= frame_count + 4'(w_spi_go);
    end
  end
endmodule
